// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data_memory write-side sequencer.
package mem_ctrl_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

endpackage

// File: rtl/mem_sweep_counter.sv
// Sweep address counter: restarts at 0 on start, counts while enabled,
// and parks at DEPTH-1 so no out-of-range address is ever produced.
module mem_sweep_counter
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          en,
    output logic [AW-1:0] cnt,
    output logic          at_tc
);

    localparam logic [AW-1:0] TC = AW'(DEPTH - 1);

    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (en && (cnt_q != TC)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt   = cnt_q;
    assign at_tc = (cnt_q == TC);

endmodule

// File: rtl/mem_write_ctrl.sv
// Write-side sequencer for data_memory: WRITE / ADD (read-modify-write) /
// CLEAR_ALL requests, plus a pass-through read channel sharing the read port.
//
// state | meaning
// IDLE  | accepting requests; issue stage may hold a WRITE/ADD being written
// SWEEP | writing CLEAR_VALUE to addresses 0..DEPTH-1, requests stalled
module mem_write_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int              SIZE           = 16,
    parameter int              DEPTH          = 64,
    parameter logic [SIZE-1:0] CLEAR_VALUE    = '0,
    parameter bit              CLEAR_ON_RESET = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [$clog2(DEPTH)-1:0] req_addr,
    input  logic [SIZE-1:0]          req_data,
    output logic [$clog2(DEPTH)-1:0] mem_waddr,
    output logic [SIZE-1:0]          mem_write_data,
    output logic                     mem_write_en,
    output logic [$clog2(DEPTH)-1:0] mem_raddr,
    input  logic [SIZE-1:0]          mem_read_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [SIZE-1:0]          rd_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     clear_done
);

    localparam int AW = $clog2(DEPTH);

    state_t          state_q, state_d;
    logic            iss_valid_q, iss_valid_d;
    logic [1:0]      iss_op_q, iss_op_d;
    logic [AW-1:0]   iss_addr_q, iss_addr_d;
    logic [SIZE-1:0] iss_data_q, iss_data_d;

    logic            sweep_start;
    logic            sweeping;
    logic            sweep_tc;
    logic [AW-1:0]   sweep_addr;
    logic            iss_add;
    logic            accept;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign sweeping  = (state_q == SWEEP);
    assign iss_add   = iss_valid_q && (iss_op_q == OP_ADD);

    always_comb begin
        state_d     = state_q;
        iss_valid_d = 1'b0;
        iss_op_d    = iss_op_q;
        iss_addr_d  = iss_addr_q;
        iss_data_d  = iss_data_q;
        sweep_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (req_op)
                        OP_WRITE, OP_ADD: begin
                            iss_valid_d = 1'b1;
                            iss_op_d    = req_op;
                            iss_addr_d  = req_addr;
                            iss_data_d  = req_data;
                        end
                        OP_CLEAR: begin
                            state_d     = SWEEP;
                            sweep_start = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            SWEEP: begin
                if (sweep_tc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= CLEAR_ON_RESET ? SWEEP : IDLE;
            iss_valid_q <= 1'b0;
            iss_op_q    <= OP_NOP;
            iss_addr_q  <= '0;
            iss_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            iss_valid_q <= iss_valid_d;
            iss_op_q    <= iss_op_d;
            iss_addr_q  <= iss_addr_d;
            iss_data_q  <= iss_data_d;
        end
    end

    mem_sweep_counter #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sweep_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (sweep_start),
        .en    (sweeping),
        .cnt   (sweep_addr),
        .at_tc (sweep_tc)
    );

    // Sweep and issue stage never overlap: a CLEAR is only accepted in IDLE
    // and leaves the issue stage empty.
    always_comb begin
        mem_write_en   = sweeping || iss_valid_q;
        mem_waddr      = sweeping ? sweep_addr : iss_addr_q;
        mem_write_data = iss_data_q;
        if (sweeping) begin
            mem_write_data = CLEAR_VALUE;
        end else if (iss_add) begin
            mem_write_data = mem_read_data + iss_data_q;
        end
    end

    assign mem_raddr  = iss_add ? iss_addr_q : rd_addr;
    assign rd_data    = mem_read_data;
    assign rd_valid   = !iss_add;
    assign busy       = sweeping || iss_valid_q;
    assign clear_done = sweeping && sweep_tc;

endmodule

// File: tb/tb_mem_write_ctrl.sv
// Directed bench for mem_write_ctrl: DEPTH=64 clear-on-reset instance and a
// DEPTH=48 instance without reset clear, each backed by a behavioural memory.
module tb_mem_write_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_op;
    logic [5:0]  req_addr;
    logic [15:0] req_data;
    logic [5:0]  rd_addr;

    logic        valid_a, ready_a, we_a, rdv_a, busy_a, done_a;
    logic [5:0]  waddr_a, raddr_a;
    logic [15:0] wdata_a, rdata_a, rdd_a;

    logic        valid_b, ready_b, we_b, rdv_b, busy_b, done_b;
    logic [5:0]  waddr_b, raddr_b;
    logic [15:0] wdata_b, rdata_b, rdd_b;

    logic [15:0] mem_a [64];
    logic [15:0] mem_b [48];

    int nvec  = 0;
    int nfail = 0;

    mem_write_ctrl #(.SIZE(16), .DEPTH(64), .CLEAR_VALUE(16'h0000), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_ready(ready_a),
        .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
        .mem_waddr(waddr_a), .mem_write_data(wdata_a), .mem_write_en(we_a),
        .mem_raddr(raddr_a), .mem_read_data(rdata_a), .rd_addr(rd_addr),
        .rd_data(rdd_a), .rd_valid(rdv_a), .busy(busy_a), .clear_done(done_a)
    );

    mem_write_ctrl #(.SIZE(16), .DEPTH(48), .CLEAR_VALUE(16'h0000), .CLEAR_ON_RESET(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_b), .req_ready(ready_b),
        .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
        .mem_waddr(waddr_b), .mem_write_data(wdata_b), .mem_write_en(we_b),
        .mem_raddr(raddr_b), .mem_read_data(rdata_b), .rd_addr(rd_addr),
        .rd_data(rdd_b), .rd_valid(rdv_b), .busy(busy_b), .clear_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) mem_a[i] = 16'hAAAA;
        for (int i = 0; i < 48; i++) mem_b[i] = 16'hAAAA;
    end

    always @(posedge clk) begin
        if (we_a) mem_a[waddr_a] <= wdata_a;
        if (we_b && (waddr_b < 6'd48)) mem_b[waddr_b] <= wdata_b;
    end

    assign rdata_a = mem_a[raddr_a];
    assign rdata_b = (raddr_b < 6'd48) ? mem_b[raddr_b] : 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [5:0]  addr;
        logic [15:0] data;
        logic        we;
        logic [5:0]  waddr;
        logic [15:0] wdata;
        logic        rdv;
        logic [15:0] rdd;
        logic        busy;
    } vec_t;

    vec_t vecs [9];

    int writes, max_addr, bad_addr, done_cnt, done_cyc, ready_hi;

    initial begin
        // valid op addr data | we waddr wdata rd_valid rd_data busy  (rd_addr = 5)
        vecs[0] = '{1'b1, OP_WRITE, 6'd5, 16'h1234, 1'b0, 6'd0, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, OP_ADD,   6'd5, 16'h0001, 1'b1, 6'd5, 16'h1234, 1'b1, 16'h0000, 1'b1};
        vecs[2] = '{1'b1, OP_WRITE, 6'd7, 16'hFFFF, 1'b1, 6'd5, 16'h1235, 1'b0, 16'h1234, 1'b1};
        vecs[3] = '{1'b1, OP_ADD,   6'd7, 16'h0002, 1'b1, 6'd7, 16'hFFFF, 1'b1, 16'h1235, 1'b1};
        vecs[4] = '{1'b1, OP_NOP,   6'd9, 16'h5555, 1'b1, 6'd7, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
        vecs[5] = '{1'b0, OP_WRITE, 6'd9, 16'h7777, 1'b0, 6'd0, 16'h0000, 1'b1, 16'h1235, 1'b0};
        vecs[6] = '{1'b1, OP_ADD,   6'd9, 16'h0003, 1'b0, 6'd0, 16'h0000, 1'b1, 16'h1235, 1'b0};
        vecs[7] = '{1'b0, OP_NOP,   6'd0, 16'h0000, 1'b1, 6'd9, 16'h0003, 1'b0, 16'h0000, 1'b1};
        vecs[8] = '{1'b0, OP_NOP,   6'd0, 16'h0000, 1'b0, 6'd0, 16'h0000, 1'b1, 16'h1235, 1'b0};

        rst_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        req_op = OP_NOP; req_addr = '0; req_data = '0; rd_addr = 6'd5;

        next_cycle();
        @(negedge clk);
        chk("rst_b_ready", 32'(ready_b), 32'd1);
        chk("rst_b_busy",  32'(busy_b),  32'd0);
        chk("rst_b_we",    32'(we_b),    32'd0);
        chk("rst_a_ready", 32'(ready_a), 32'd0);
        chk("rst_a_busy",  32'(busy_a),  32'd1);
        chk("rst_a_done",  32'(done_a),  32'd0);
        next_cycle();

        // Reset sweep on instance A: first low-reset edge already taken
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) next_cycle();
            @(negedge clk);
            chk($sformatf("sweep_a_we[%0d]", i),    32'(we_a),    32'd1);
            chk($sformatf("sweep_a_waddr[%0d]", i), 32'(waddr_a), 32'(i));
            chk($sformatf("sweep_a_done[%0d]", i),  32'(done_a),  32'(i == 63));
            chk($sformatf("sweep_a_ready[%0d]", i), 32'(ready_a), 32'd0);
        end
        next_cycle();
        @(negedge clk);
        chk("post_sweep_a_ready", 32'(ready_a), 32'd1);
        chk("post_sweep_a_busy",  32'(busy_a),  32'd0);
        chk("post_sweep_a_we",    32'(we_a),    32'd0);
        chk("post_sweep_a_mem63", 32'(mem_a[63]), 32'h0);
        chk("post_sweep_a_mem0",  32'(mem_a[0]),  32'h0);

        // Table-driven WRITE / ADD / NOP vectors on A
        for (int r = 0; r < 9; r++) begin
            next_cycle();
            valid_a  = vecs[r].valid;
            req_op   = vecs[r].op;
            req_addr = vecs[r].addr;
            req_data = vecs[r].data;
            @(negedge clk);
            chk($sformatf("vec%0d_we", r),    32'(we_a),    32'(vecs[r].we));
            if (vecs[r].we) begin
                chk($sformatf("vec%0d_waddr", r), 32'(waddr_a), 32'(vecs[r].waddr));
                chk($sformatf("vec%0d_wdata", r), 32'(wdata_a), 32'(vecs[r].wdata));
            end
            chk($sformatf("vec%0d_rd_valid", r), 32'(rdv_a),   32'(vecs[r].rdv));
            chk($sformatf("vec%0d_rd_data", r),  32'(rdd_a),   32'(vecs[r].rdd));
            chk($sformatf("vec%0d_busy", r),     32'(busy_a),  32'(vecs[r].busy));
            chk($sformatf("vec%0d_ready", r),    32'(ready_a), 32'd1);
        end
        valid_a = 1'b0;
        chk("mem_a5",  32'(mem_a[5]), 32'h1235);
        chk("mem_a7",  32'(mem_a[7]), 32'h0001);
        chk("mem_a9",  32'(mem_a[9]), 32'h0003);

        // CLEAR_ALL held valid across a DEPTH=48 sweep on B
        writes = 0; max_addr = 0; bad_addr = 0; done_cnt = 0; done_cyc = -1; ready_hi = 0;
        for (int c = 0; c < 55; c++) begin
            next_cycle();
            valid_b = (c <= 48);
            req_op  = OP_CLEAR;
            @(negedge clk);
            if (c == 0)  chk("hold_b_ready_accept", 32'(ready_b), 32'd1);
            if (c == 49) chk("hold_b_ready_return", 32'(ready_b), 32'd1);
            if (we_b) begin
                writes++;
                if (int'(waddr_b) > max_addr) max_addr = int'(waddr_b);
                if (waddr_b >= 6'd48) bad_addr++;
            end
            if (done_b) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c >= 1 && c <= 48 && ready_b) ready_hi++;
        end
        valid_b = 1'b0;
        chk("hold_b_writes",    32'(writes),   32'd48);
        chk("hold_b_max_addr",  32'(max_addr), 32'd47);
        chk("hold_b_bad_addr",  32'(bad_addr), 32'd0);
        chk("hold_b_done_cnt",  32'(done_cnt), 32'd1);
        chk("hold_b_done_cyc",  32'(done_cyc), 32'd48);
        chk("hold_b_ready_hi",  32'(ready_hi), 32'd0);
        chk("hold_b_mem47",     32'(mem_b[47]), 32'h0);
        chk("hold_b_mem0",      32'(mem_b[0]),  32'h0);

        // Reset while B is writing sweep address 20
        next_cycle();
        valid_b = 1'b1;
        req_op  = OP_CLEAR;
        @(negedge clk);
        chk("abort_b_accept", 32'(ready_b), 32'd1);
        done_cnt = 0;
        for (int k = 1; k <= 21; k++) begin
            next_cycle();
            valid_b = 1'b0;
            if (k == 21) rst_n = 1'b0;
            @(negedge clk);
            if (done_b) done_cnt++;
            if (k == 21) begin
                chk("abort_b_we20",    32'(we_b),    32'd1);
                chk("abort_b_waddr20", 32'(waddr_b), 32'd20);
            end
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_b_ready", 32'(ready_b), 32'd1);
        chk("abort_b_busy",  32'(busy_b),  32'd0);
        chk("abort_b_we",    32'(we_b),    32'd0);
        chk("abort_b_done",  32'(done_b),  32'd0);
        chk("abort_a_ready", 32'(ready_a), 32'd0);
        chk("abort_a_busy",  32'(busy_a),  32'd1);
        writes = 0;
        for (int k = 0; k < 60; k++) begin
            next_cycle();
            @(negedge clk);
            if (done_b) done_cnt++;
            if (we_b) writes++;
        end
        chk("abort_b_no_done",   32'(done_cnt), 32'd0);
        chk("abort_b_no_writes", 32'(writes),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
